ahb_lite_master: RTL and testbench

- Single-outstanding-address, pipelined AHB-Lite initiator that turns a valid/ready command stream into word transfers.
- Returns one response per command.
- It is the driving end of the bus that our AHB slaves (GPIO and others) respond to. Used by the peripheral benches in place of hand-written bus tasks, and as the bus front end of small controllers.
- Overlaps the address phase of transfer N+1 with the data phase of transfer N. Honours wait states and two-cycle ERROR responses.

---
 rtl/ahb_pkg.sv | 15 +
 rtl/ahb_lite_master.sv | 152 +++++++++++++++
 tb/tb_ahb_lite_master.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite transfer types and bus constants.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    localparam logic [2:0] HSIZE_WORD  = 3'b010;
    localparam logic       HRESP_OKAY  = 1'b0;
    localparam logic       HRESP_ERROR = 1'b1;

endpackage

// File: rtl/ahb_lite_master.sv
// Pipelined AHB-Lite initiator: one address phase and one data phase in
// flight, fed from a valid/ready command stream, one response per command.
module ahb_lite_master #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic              rsp_write,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] HADDR,
    output logic [1:0]        HTRANS,
    output logic              HWRITE,
    output logic [2:0]        HSIZE,
    output logic              HSEL,
    output logic [DATA_W-1:0] HWDATA,
    input  logic              HREADY,
    input  logic              HRESP,
    input  logic [DATA_W-1:0] HRDATA
);
    import ahb_pkg::*;

    // Address-phase register; only the word address is kept.
    logic                aValid_q, aValid_d;
    logic [ADDR_W-1:2]   aAddr_q, aAddr_d;
    logic                aWrite_q, aWrite_d;
    logic [DATA_W-1:0]   aWdata_q, aWdata_d;

    // Data-phase register.
    logic                dValid_q, dValid_d;
    logic                dWrite_q, dWrite_d;
    logic [DATA_W-1:0]   dWdata_q, dWdata_d;

    // Second cycle of a two-cycle ERROR response.
    logic                cancel_q, cancel_d;

    // Response register.
    logic                rspValid_q, rspValid_d;
    logic                rspWrite_q, rspWrite_d;
    logic                rspErr_q, rspErr_d;
    logic [DATA_W-1:0]   rspRdata_q, rspRdata_d;

    logic                advance;
    logic                accept;
    logic                complete;
    htrans_t             htrans;
    logic                unusedAddrBits;

    // Byte-lane bits of the command address play no part in word transfers.
    assign unusedAddrBits = ^cmd_addr[1:0];

    // The pipeline moves only on a ready bus outside the ERROR cancel cycle.
    assign advance   = HREADY && !cancel_q;
    assign cmd_ready = !aValid_q || advance;
    assign accept    = cmd_valid && cmd_ready;
    assign complete  = dValid_q && HREADY;

    // A pending address is suppressed during the cancel cycle and re-issued after it.
    assign htrans = (aValid_q && !cancel_q) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign HTRANS = htrans;
    assign HSEL   = HTRANS[1];
    assign HADDR  = {aAddr_q, 2'b00};
    assign HWRITE = aWrite_q;
    assign HSIZE  = HSIZE_WORD;
    assign HWDATA = (dValid_q && dWrite_q) ? dWdata_q : '0;

    assign rsp_valid = rspValid_q;
    assign rsp_write = rspWrite_q;
    assign rsp_err   = rspErr_q;
    assign rsp_rdata = rspRdata_q;

    // Next-state logic for both pipeline stages, the cancel flag and the response.
    always_comb begin
        aValid_d   = aValid_q;
        aAddr_d    = aAddr_q;
        aWrite_d   = aWrite_q;
        aWdata_d   = aWdata_q;
        dValid_d   = dValid_q;
        dWrite_d   = dWrite_q;
        dWdata_d   = dWdata_q;
        cancel_d   = 1'b0;
        rspValid_d = 1'b0;
        rspWrite_d = 1'b0;
        rspErr_d   = 1'b0;
        rspRdata_d = '0;

        if (advance) begin
            dValid_d = aValid_q;
            dWrite_d = aWrite_q;
            dWdata_d = aWdata_q;
            aValid_d = 1'b0;
        end else if (complete) begin
            dValid_d = 1'b0;
        end

        // Address and direction are kept when the stage empties so an idle bus holds them.
        if (accept) begin
            aValid_d = 1'b1;
            aAddr_d  = cmd_addr[ADDR_W-1:2];
            aWrite_d = cmd_write;
            aWdata_d = cmd_wdata;
        end

        cancel_d = dValid_q && (HRESP == HRESP_ERROR) && !HREADY;

        if (complete) begin
            rspValid_d = 1'b1;
            rspWrite_d = dWrite_q;
            rspErr_d   = (HRESP == HRESP_ERROR);
            rspRdata_d = dWrite_q ? '0 : HRDATA;
        end
    end

    // State registers with synchronous reset that drops everything in flight.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            aValid_q   <= 1'b0;
            aAddr_q    <= '0;
            aWrite_q   <= 1'b0;
            aWdata_q   <= '0;
            dValid_q   <= 1'b0;
            dWrite_q   <= 1'b0;
            dWdata_q   <= '0;
            cancel_q   <= 1'b0;
            rspValid_q <= 1'b0;
            rspWrite_q <= 1'b0;
            rspErr_q   <= 1'b0;
            rspRdata_q <= '0;
        end else begin
            aValid_q   <= aValid_d;
            aAddr_q    <= aAddr_d;
            aWrite_q   <= aWrite_d;
            aWdata_q   <= aWdata_d;
            dValid_q   <= dValid_d;
            dWrite_q   <= dWrite_d;
            dWdata_q   <= dWdata_d;
            cancel_q   <= cancel_d;
            rspValid_q <= rspValid_d;
            rspWrite_q <= rspWrite_d;
            rspErr_q   <= rspErr_d;
            rspRdata_q <= rspRdata_d;
        end
    end

endmodule

// File: tb/tb_ahb_lite_master.sv
// Directed bench for ahb_lite_master against a small behavioural AHB slave
// with programmable wait states and a two-cycle ERROR on one address.
module tb_ahb_lite_master;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_write, rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] HADDR, HWDATA, HRDATA;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic        HWRITE, HSEL, HREADY, HRESP;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    typedef struct { int period; logic write; logic [31:0] rdata; logic err; } rsp_t;
    typedef struct { int period; logic [31:0] addr; logic write; } nonseq_t;
    rsp_t    rspQ[$];
    nonseq_t nonseqQ[$];

    // Slave model state and its test controls.
    logic        sDpValid, sDpWrite;
    logic [31:0] sDpAddr;
    int          sWaitLeft;
    logic [1:0]  sErrPhase;
    logic [31:0] mem [16];
    logic [31:0] waitAddr, errAddr;
    int          waitCount;
    logic        errArmed;

    ahb_lite_master #(.ADDR_W(32), .DATA_W(32)) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HSEL(HSEL),
        .HWDATA(HWDATA), .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA)
    );

    // Free-running 10-unit bus clock.
    always #5 HCLK = ~HCLK;

    // Cycle counter; a period is numbered by the edges seen before it.
    always @(posedge HCLK) cycle <= cycle + 1;

    // Slave outputs: wait states first, then the low-HREADY half of an ERROR.
    assign HREADY = !sDpValid ? 1'b1 : (sWaitLeft > 0) ? 1'b0 : (sErrPhase == 2'd1) ? 1'b0 : 1'b1;
    assign HRESP  = sDpValid && (sWaitLeft == 0) && (sErrPhase != 2'd0);
    assign HRDATA = (sDpValid && !sDpWrite) ? mem[sDpAddr[5:2]] : 32'h0;

    // Slave sequencing: capture address phases, count waits, commit writes.
    always @(posedge HCLK) begin
        if (HRESET) begin
            sDpValid  <= 1'b0;
            sWaitLeft <= 0;
            sErrPhase <= 2'd0;
            for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
        end else if (HREADY) begin
            if (sDpValid && sDpWrite && sErrPhase == 2'd0) mem[sDpAddr[5:2]] <= HWDATA;
            if (HSEL && HTRANS[1]) begin
                sDpValid  <= 1'b1;
                sDpAddr   <= HADDR;
                sDpWrite  <= HWRITE;
                sWaitLeft <= (waitCount > 0 && HADDR == waitAddr) ? waitCount : 0;
                sErrPhase <= (errArmed && HADDR == errAddr) ? 2'd1 : 2'd0;
            end else begin
                sDpValid  <= 1'b0;
                sErrPhase <= 2'd0;
            end
        end else if (sWaitLeft > 0) begin
            sWaitLeft <= sWaitLeft - 1;
        end else if (sErrPhase == 2'd1) begin
            sErrPhase <= 2'd2;
        end
    end

    // Log every response pulse and every NONSEQ address phase with its period.
    always @(negedge HCLK) begin
        if (rsp_valid) rspQ.push_back(rsp_t'{cycle, rsp_write, rsp_rdata, rsp_err});
        if (HTRANS == 2'b10) nonseqQ.push_back(nonseq_t'{cycle, HADDR, HWRITE});
    end

    task automatic tick();
        @(negedge HCLK);
        #1;
    endtask

    // Offer one command until accepted; returns the period in which it was accepted.
    task automatic issueCmd(input logic w, input logic [31:0] a, input logic [31:0] d, output int acc);
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        acc = -1;
        for (int k = 0; k < 20; k++) begin
            if (cmd_ready) begin
                acc = cycle;
                break;
            end
            tick();
        end
        checks++; if (acc < 0) begin errors++; $display("[TB] FAIL cmd_accept got no cmd_ready expected accept within 20 cycles"); end
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic waitRsp(input int n);
        for (int k = 0; k < 50; k++) begin
            if (rspQ.size() >= n) break;
            tick();
        end
        checks++; if (rspQ.size() < n) begin errors++; $display("[TB] FAIL rsp_count got %0d expected %0d", rspQ.size(), n); end
    endtask

    task automatic test_reset();
        HRESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'h0; cmd_wdata = 32'h0;
        waitAddr = 32'h0; waitCount = 0; errAddr = 32'h0; errArmed = 1'b0;
        tick(); tick();
        HRESET = 1'b0;
        tick();
        checks++; if (HTRANS !== 2'b00) begin errors++; $display("[TB] FAIL reset_htrans got %b expected 00", HTRANS); end
        checks++; if (HSEL !== 1'b0) begin errors++; $display("[TB] FAIL reset_hsel got %b expected 0", HSEL); end
        checks++; if (HADDR !== 32'h0) begin errors++; $display("[TB] FAIL reset_haddr got %h expected 0", HADDR); end
        checks++; if (HWRITE !== 1'b0) begin errors++; $display("[TB] FAIL reset_hwrite got %b expected 0", HWRITE); end
        checks++; if (HWDATA !== 32'h0) begin errors++; $display("[TB] FAIL reset_hwdata got %h expected 0", HWDATA); end
        checks++; if (HSIZE !== 3'b010) begin errors++; $display("[TB] FAIL reset_hsize got %b expected 010", HSIZE); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_cmd_ready got %b expected 1", cmd_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp_valid got %b expected 0", rsp_valid); end
        checks++; if (rsp_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp_err got %b expected 0", rsp_err); end
        checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_rsp_rdata got %h expected 0", rsp_rdata); end
        rspQ.delete(); nonseqQ.delete();
        repeat (4) tick();
        checks++; if (rspQ.size() != 0) begin errors++; $display("[TB] FAIL idle_rsp got %0d pulses expected 0", rspQ.size()); end
        checks++; if (nonseqQ.size() != 0) begin errors++; $display("[TB] FAIL idle_nonseq got %0d transfers expected 0", nonseqQ.size()); end
    endtask

    task automatic test_write_read();
        int acc, acc2;
        rspQ.delete(); nonseqQ.delete();
        issueCmd(1'b1, 32'h0000_0004, 32'h0000_00A5, acc);
        checks++; if (HTRANS !== 2'b10) begin errors++; $display("[TB] FAIL wr_htrans got %b expected 10", HTRANS); end
        checks++; if (HADDR !== 32'h4) begin errors++; $display("[TB] FAIL wr_haddr got %h expected 4", HADDR); end
        checks++; if (HWRITE !== 1'b1) begin errors++; $display("[TB] FAIL wr_hwrite got %b expected 1", HWRITE); end
        checks++; if (HSEL !== 1'b1) begin errors++; $display("[TB] FAIL wr_hsel got %b expected 1", HSEL); end
        tick();
        checks++; if (HWDATA !== 32'hA5) begin errors++; $display("[TB] FAIL wr_hwdata got %h expected a5", HWDATA); end
        checks++; if (HTRANS !== 2'b00) begin errors++; $display("[TB] FAIL wr_data_htrans got %b expected 00", HTRANS); end
        tick();
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("[TB] FAIL wr_rsp_valid got %b expected 1", rsp_valid); end
        checks++; if (rsp_write !== 1'b1) begin errors++; $display("[TB] FAIL wr_rsp_write got %b expected 1", rsp_write); end
        checks++; if (rsp_err !== 1'b0) begin errors++; $display("[TB] FAIL wr_rsp_err got %b expected 0", rsp_err); end
        checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("[TB] FAIL wr_rsp_rdata got %h expected 0", rsp_rdata); end
        issueCmd(1'b0, 32'h0000_0007, 32'h0, acc2);
        checks++; if (acc2 != acc + 3) begin errors++; $display("[TB] FAIL rd_accept got period %0d expected %0d", acc2, acc + 3); end
        checks++; if (HTRANS !== 2'b10) begin errors++; $display("[TB] FAIL rd_htrans got %b expected 10", HTRANS); end
        checks++; if (HADDR !== 32'h4) begin errors++; $display("[TB] FAIL rd_haddr got %h expected 4", HADDR); end
        checks++; if (HWRITE !== 1'b0) begin errors++; $display("[TB] FAIL rd_hwrite got %b expected 0", HWRITE); end
        tick();
        checks++; if (HWDATA !== 32'h0) begin errors++; $display("[TB] FAIL rd_hwdata got %h expected 0", HWDATA); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL rd_rsp_early got %b expected 0", rsp_valid); end
        tick();
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("[TB] FAIL rd_rsp_valid got %b expected 1", rsp_valid); end
        checks++; if (rsp_rdata !== 32'hA5) begin errors++; $display("[TB] FAIL rd_rsp_rdata got %h expected a5", rsp_rdata); end
        checks++; if (rsp_err !== 1'b0) begin errors++; $display("[TB] FAIL rd_rsp_err got %b expected 0", rsp_err); end
        checks++; if (rsp_write !== 1'b0) begin errors++; $display("[TB] FAIL rd_rsp_write got %b expected 0", rsp_write); end
    endtask

    task automatic test_back_to_back();
        int acc[4];
        int rdAcc;
        rspQ.delete(); nonseqQ.delete();
        for (int i = 0; i < 4; i++) issueCmd(1'b1, 32'(i * 4), 32'(i + 1), acc[i]);
        for (int i = 1; i < 4; i++) begin
            checks++; if (acc[i] != acc[0] + i) begin errors++; $display("[TB] FAIL b2b_accept%0d got period %0d expected %0d", i, acc[i], acc[0] + i); end
        end
        waitRsp(4);
        checks++; if (nonseqQ.size() != 4) begin errors++; $display("[TB] FAIL b2b_nonseq_count got %0d expected 4", nonseqQ.size()); end
        for (int i = 0; i < 4 && i < nonseqQ.size(); i++) begin
            checks++; if (nonseqQ[i].period != acc[0] + 1 + i) begin errors++; $display("[TB] FAIL b2b_nonseq_period%0d got %0d expected %0d", i, nonseqQ[i].period, acc[0] + 1 + i); end
            checks++; if (nonseqQ[i].addr !== 32'(i * 4)) begin errors++; $display("[TB] FAIL b2b_haddr%0d got %h expected %h", i, nonseqQ[i].addr, i * 4); end
        end
        for (int i = 0; i < 4 && i < rspQ.size(); i++) begin
            checks++; if (rspQ[i].period != acc[0] + 3 + i) begin errors++; $display("[TB] FAIL b2b_rsp_period%0d got %0d expected %0d", i, rspQ[i].period, acc[0] + 3 + i); end
            checks++; if (rspQ[i].err !== 1'b0 || rspQ[i].write !== 1'b1) begin errors++; $display("[TB] FAIL b2b_rsp%0d got err %b write %b expected err 0 write 1", i, rspQ[i].err, rspQ[i].write); end
        end
        issueCmd(1'b0, 32'h8, 32'h0, rdAcc);
        waitRsp(5);
        if (rspQ.size() > 4) begin
            checks++; if (rspQ[4].rdata !== 32'h3) begin errors++; $display("[TB] FAIL b2b_readback got %h expected 3", rspQ[4].rdata); end
        end
    endtask

    task automatic test_wait_states();
        int a0, a1, a2;
        rspQ.delete(); nonseqQ.delete();
        waitAddr = 32'h4; waitCount = 2;
        issueCmd(1'b0, 32'h0, 32'h0, a0);
        issueCmd(1'b0, 32'h4, 32'h0, a1);
        issueCmd(1'b0, 32'h8, 32'h0, a2);
        checks++; if (a1 != a0 + 1 || a2 != a0 + 2) begin errors++; $display("[TB] FAIL ws_accept got %0d/%0d expected %0d/%0d", a1, a2, a0 + 1, a0 + 2); end
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("[TB] FAIL ws_cmd_ready got %b expected 0", cmd_ready); end
        for (int j = 0; j < 3; j++) begin
            checks++; if (HTRANS !== 2'b10 || HADDR !== 32'h8) begin errors++; $display("[TB] FAIL ws_hold%0d got %b/%h expected 10/8", j, HTRANS, HADDR); end
            tick();
        end
        checks++; if (HTRANS !== 2'b00) begin errors++; $display("[TB] FAIL ws_release got %b expected 00", HTRANS); end
        waitRsp(3);
        if (rspQ.size() >= 3) begin
            checks++; if (rspQ[0].period != a0 + 3 || rspQ[0].rdata !== 32'h1) begin errors++; $display("[TB] FAIL ws_rsp0 got %0d/%h expected %0d/1", rspQ[0].period, rspQ[0].rdata, a0 + 3); end
            checks++; if (rspQ[1].period != a0 + 6 || rspQ[1].rdata !== 32'h2) begin errors++; $display("[TB] FAIL ws_rsp1 got %0d/%h expected %0d/2", rspQ[1].period, rspQ[1].rdata, a0 + 6); end
            checks++; if (rspQ[2].period != a0 + 7 || rspQ[2].rdata !== 32'h3) begin errors++; $display("[TB] FAIL ws_rsp2 got %0d/%h expected %0d/3", rspQ[2].period, rspQ[2].rdata, a0 + 7); end
        end
        waitCount = 0;
    endtask

    task automatic test_error();
        int aw, ar;
        rspQ.delete(); nonseqQ.delete();
        errAddr = 32'hFFFF_FFF0; errArmed = 1'b1;
        issueCmd(1'b1, 32'hFFFF_FFF0, 32'hDEAD_BEEF, aw);
        issueCmd(1'b0, 32'h0, 32'h0, ar);
        checks++; if (ar != aw + 1) begin errors++; $display("[TB] FAIL err_accept got %0d expected %0d", ar, aw + 1); end
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("[TB] FAIL err_first_cmd_ready got %b expected 0", cmd_ready); end
        tick();
        checks++; if (HTRANS !== 2'b00) begin errors++; $display("[TB] FAIL err_cancel_htrans got %b expected 00", HTRANS); end
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("[TB] FAIL err_cancel_cmd_ready got %b expected 0", cmd_ready); end
        checks++; if (HSEL !== 1'b0) begin errors++; $display("[TB] FAIL err_cancel_hsel got %b expected 0", HSEL); end
        tick();
        checks++; if (HTRANS !== 2'b10 || HADDR !== 32'h0 || HWRITE !== 1'b0) begin errors++; $display("[TB] FAIL err_reissue got %b/%h/%b expected 10/0/0", HTRANS, HADDR, HWRITE); end
        checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_write !== 1'b1) begin errors++; $display("[TB] FAIL err_rsp got v%b e%b w%b expected v1 e1 w1", rsp_valid, rsp_err, rsp_write); end
        errArmed = 1'b0;
        waitRsp(2);
        repeat (3) tick();
        checks++; if (rspQ.size() != 2) begin errors++; $display("[TB] FAIL err_rsp_count got %0d expected 2", rspQ.size()); end
        if (rspQ.size() >= 2) begin
            checks++; if (rspQ[1].err !== 1'b0 || rspQ[1].rdata !== 32'h1 || rspQ[1].period != aw + 6) begin errors++; $display("[TB] FAIL err_second got e%b %h p%0d expected e0 1 p%0d", rspQ[1].err, rspQ[1].rdata, rspQ[1].period, aw + 6); end
        end
    endtask

    task automatic test_reset_mid();
        int a;
        rspQ.delete(); nonseqQ.delete();
        waitAddr = 32'h4; waitCount = 5;
        issueCmd(1'b0, 32'h4, 32'h0, a);
        tick();
        HRESET = 1'b1;
        tick();
        HRESET = 1'b0;
        checks++; if (HTRANS !== 2'b00 || HSEL !== 1'b0) begin errors++; $display("[TB] FAIL mid_htrans got %b/%b expected 00/0", HTRANS, HSEL); end
        checks++; if (HADDR !== 32'h0 || HWRITE !== 1'b0) begin errors++; $display("[TB] FAIL mid_haddr got %h/%b expected 0/0", HADDR, HWRITE); end
        checks++; if (HWDATA !== 32'h0) begin errors++; $display("[TB] FAIL mid_hwdata got %h expected 0", HWDATA); end
        checks++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin errors++; $display("[TB] FAIL mid_rsp got %b/%b/%h expected 0/0/0", rsp_valid, rsp_err, rsp_rdata); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL mid_cmd_ready got %b expected 1", cmd_ready); end
        repeat (6) tick();
        checks++; if (rspQ.size() != 0) begin errors++; $display("[TB] FAIL mid_dropped got %0d responses expected 0", rspQ.size()); end
        waitCount = 0;
    endtask

    // Scenario sequence and summary.
    initial begin
        test_reset();
        test_write_read();
        test_back_to_back();
        test_wait_states();
        test_error();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Guard against a stalled run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog got no completion expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
